vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Shares one single-port synchronous framebuffer RAM between the VGA scan-out
//  (display port) and a host read/write port. Display reads have absolute
//  priority. Host accesses are queued in an in-order request FIFO and issued on
//  idle RAM cycles. Sits between the VGA timing/pixel logic and the pixel RAM.
// PARAMETERS
//  ADDR_W      17  RAM word address width (320x240 = 76800 words)
//  DATA_W      3   pixel width, {R,G,B}
//  FIFO_DEPTH  4   host request FIFO entries (power of two, >=2)
//  MAX_WAIT    800 host head-of-queue wait, in cycles, before host_starve asserts
// PORTS
//  clk          in   1       pixel clock, 25 MHz
//  rst          in   1       synchronous, active-high reset
//  disp_req     in   1       display read request this cycle
//  disp_addr    in   ADDR_W  display read address
//  disp_valid   out  1       disp_rdata valid (1-cycle pulse)
//  disp_rdata   out  DATA_W  display read data
//  host_valid   in   1       host request valid
//  host_ready   out  1       FIFO can accept (= !full)
//  host_we      in   1       1 = write, 0 = read
//  host_addr    in   ADDR_W  host address
//  host_wdata   in   DATA_W  host write data
//  host_rvalid  out  1       host_rdata valid (1-cycle pulse, request order)
//  host_rdata   out  DATA_W  host read data
//  host_starve  out  1       FIFO head has waited > MAX_WAIT cycles
//  ram_en       out  1       RAM enable
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after ram_en && !ram_we
// BEHAVIOUR
//  - Reset: all outputs 0 except host_ready=0 during rst, 1 the cycle after.
//    FIFO, wait counter and read pipeline cleared; in-flight reads are dropped
//    (no disp_valid/host_rvalid for them).
//  - Host handshake: push on host_valid && host_ready. FIFO entry = {we,addr,wdata}.
//    Push to an empty FIFO is issued no earlier than the following cycle.
//  - Grant FSM (registered), evaluated each edge:
//    S_IDLE: ram_en=0. S_DISP: display read issued. S_HOST: FIFO head issued.
//    Next state: disp_req -> S_DISP; else FIFO non-empty -> S_HOST; else S_IDLE.
//    Transitions are legal from any state to any state.
//  - ram_* are registered: a request sampled at edge k drives ram_* after edge k.
//  - S_HOST pops the FIFO head on the same edge; push+pop on the same edge leaves
//    the count unchanged. Full FIFO: host_ready=0, pop frees the slot next cycle.
//  - Read return: a 2-stage tag pipe {valid,is_disp} follows each issued read;
//    data registered from ram_rdata. Display latency is exactly 2 cycles,
//    disp_req at edge k -> disp_valid after edge k+2. Host reads return in order,
//    2 cycles after issue. Writes produce no response.
//  - Host write followed by host read of the same address returns the new data
//    (FIFO order plus RAM ordering guarantee this; no bypass logic).
//  - Wait counter: counts cycles while FIFO non-empty and no pop; clears on pop
//    or empty; saturates at MAX_WAIT+1; host_starve = (count > MAX_WAIT).
//  - Display is never stalled or reordered; a continuous disp_req starves the host.
// STRUCTURE
//  - vga_pkg: ADDR_W/DATA_W defaults, H/V timing constants, grant state encoding.
//  - Sub-module fb_req_fifo: synchronous FIFO (push/pop/full/empty/head), reused
//    elsewhere. Arbiter FSM, tag pipe and wait counter stay in vga_fb_arbiter.
// TESTING
//  1. rst high 8 cycles, then low -> all outputs 0 during reset, host_ready=1 after.
//  2. disp_req at addr 0x00010 with RAM holding 3'b101 -> disp_valid 2 cycles later,
//     disp_rdata=3'b101; host FIFO untouched.
//  3. host write 0x00020<=3'b110, then host read 0x00020, disp_req low ->
//     host_rvalid with host_rdata=3'b110, exactly 2 cycles after read issue.
//  4. 5 back-to-back host writes, disp_req held high -> host_ready drops after 4th
//     push; after disp_req drops, entries drain in order, one per cycle.
//  5. disp_req high 801 cycles with one host write queued -> host_starve rises
//     after 801st wait cycle, clears the cycle after the write issues.
//  6. rst asserted one cycle after a host read issue -> no host_rvalid, FIFO empty.

Source files
------------

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer arbiter: default bus widths,
// VGA 640x480@60 timing, grant state encoding and the read-return tag.
package vga_fb_arbiter_pkg;

    localparam int DEF_ADDR_W     = 17;
    localparam int DEF_DATA_W     = 3;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // A host request may wait through one full scan line before it is flagged.
    localparam int DEF_MAX_WAIT = H_TOTAL;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_HOST = 2'd2
    } grant_state_t;

    typedef struct packed {
        logic valid;
        logic is_disp;
    } rd_tag_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host-side request/response bus of the framebuffer arbiter.
interface vga_fb_arbiter_if
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/vga_fb_arbiter_fifo.sv
// Small synchronous FIFO with a combinational head, used to queue host requests.
module fb_req_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; the pointers alone define which entries are live.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign level = count_reg;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads always win, host requests
// are queued in order and issued on otherwise idle RAM cycles.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_rdata,
    vga_fb_arbiter_if.slave   host,
    output logic              host_starve,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int REQ_W  = 1 + ADDR_W + DATA_W;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);

    grant_state_t      state_reg, state_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
    rd_tag_t           tag1_reg, tag2_reg, tag_next;
    logic              disp_valid_reg, host_rvalid_reg;
    logic [DATA_W-1:0] disp_rdata_reg, host_rdata_reg;
    logic              ready_reg, ready_next;
    logic [WAIT_W-1:0] wait_reg;

    logic [REQ_W-1:0]  fifo_din, fifo_head;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              push, pop;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    assign fifo_din = {host.we, host.addr, host.wdata};
    assign {head_we, head_addr, head_wdata} = fifo_head;
    assign push = host.valid && ready_reg;
    assign pop  = (state_next == S_HOST);

    fb_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_next     = S_IDLE;
        ram_we_next    = 1'b0;
        ram_addr_next  = '0;
        ram_wdata_next = '0;
        tag_next       = '0;
        if (disp_req) begin
            state_next       = S_DISP;
            ram_addr_next    = disp_addr;
            tag_next.valid   = 1'b1;
            tag_next.is_disp = 1'b1;
        end else if (!fifo_empty) begin
            state_next     = S_HOST;
            ram_we_next    = head_we;
            ram_addr_next  = head_addr;
            ram_wdata_next = head_wdata;
            tag_next.valid = !head_we;
        end
    end

    // host_ready is registered, so predict fullness after this edge's push/pop.
    always_comb begin
        ready_next = !((fifo_full && !pop) ||
                       ((fifo_level == LVL_W'(FIFO_DEPTH - 1)) && push && !pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            ready_reg     <= ready_next;
        end
    end

    // Tag follows the read through the RAM's one-cycle latency; data lands one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_reg        <= '0;
            tag2_reg        <= '0;
            disp_valid_reg  <= 1'b0;
            host_rvalid_reg <= 1'b0;
            disp_rdata_reg  <= '0;
            host_rdata_reg  <= '0;
        end else begin
            tag1_reg        <= tag_next;
            tag2_reg        <= tag1_reg;
            disp_valid_reg  <= tag2_reg.valid && tag2_reg.is_disp;
            host_rvalid_reg <= tag2_reg.valid && !tag2_reg.is_disp;
            if (tag2_reg.valid && tag2_reg.is_disp)  disp_rdata_reg <= ram_rdata;
            if (tag2_reg.valid && !tag2_reg.is_disp) host_rdata_reg <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_empty || pop) begin
            wait_reg <= '0;
        end else if (wait_reg <= WAIT_W'(MAX_WAIT)) begin
            wait_reg <= wait_reg + 1'b1;
        end
    end

    assign ram_en      = (state_reg != S_IDLE);
    assign ram_we      = ram_we_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_wdata   = ram_wdata_reg;
    assign disp_valid  = disp_valid_reg;
    assign disp_rdata  = disp_rdata_reg;
    assign host.ready  = ready_reg;
    assign host.rvalid = host_rvalid_reg;
    assign host.rdata  = host_rdata_reg;
    assign host_starve = (wait_reg > WAIT_W'(MAX_WAIT));

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a behavioural single-port RAM.
module tb_vga_fb_arbiter;
    localparam int AW        = 17;
    localparam int DW        = 3;
    localparam int RAM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_valid;
    logic [DW-1:0] disp_rdata;
    logic          host_starve;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          mem_clear;

    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host ();

    vga_fb_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .MAX_WAIT   (800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .disp_rdata  (disp_rdata),
        .host        (host),
        .host_starve (host_starve),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    logic [DW-1:0] ram_mem [RAM_WORDS];
    logic [DW-1:0] shadow  [RAM_WORDS];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= '0;
            ram_mem[16] <= 3'b101;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t             disp_q[$];
    logic [DW-1:0]    host_q[$];
    int               host_due_q[$];
    logic [AW+DW-1:0] wr_q[$];
    int               wr_cycles[$];
    int               cyc = 0;
    int               rvalid_cnt = 0;
    int               disp_cnt = 0;
    int               en_cnt = 0;
    logic             disp_samp = 1'b0;
    logic [AW-1:0]    disp_addr_samp = '0;

    always @(posedge clk) begin
        cyc            <= cyc + 1;
        disp_samp      <= disp_req && !rst;
        disp_addr_samp <= disp_addr;
    end

    always @(negedge clk) begin
        exp_t             d;
        logic [AW+DW-1:0] w;
        if (disp_samp) begin
            d.data = shadow[disp_addr_samp];
            d.due  = cyc + 2;
            disp_q.push_back(d);
        end
        if (ram_en === 1'b1) en_cnt++;
        if (ram_en === 1'b1 && ram_we === 1'b0 && !disp_samp) host_due_q.push_back(cyc + 2);
        if (ram_en === 1'b1 && ram_we === 1'b1) begin
            wr_cycles.push_back(cyc);
            chk("ram_wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                chk("ram_wr_addr_data", 32'({ram_addr, ram_wdata}), 32'(w));
            end
        end
        if (disp_valid === 1'b1) begin
            disp_cnt++;
            chk("disp_expected", 32'(disp_q.size() != 0), 32'd1);
            if (disp_q.size() != 0) begin
                d = disp_q.pop_front();
                chk("disp_rdata", 32'(disp_rdata), 32'(d.data));
                chk("disp_latency", 32'(cyc), 32'(d.due));
            end
        end
        if (host.rvalid === 1'b1) begin
            rvalid_cnt++;
            chk("host_rvalid_expected", 32'(host_q.size() != 0), 32'd1);
            if (host_q.size() != 0) chk("host_rdata", 32'(host.rdata), 32'(host_q.pop_front()));
            if (host_due_q.size() != 0) chk("host_latency", 32'(cyc), 32'(host_due_q.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int budget = 50;
        host.valid = 1'b1;
        host.we    = we;
        host.addr  = a;
        host.wdata = d;
        while (host.ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        chk("push_ready", 32'(host.ready), 32'd1);
        if (host.ready === 1'b1) begin
            $display("push we=%0d addr=0x%05h wdata=%0d at cycle %0d", we, a, d, cyc + 1);
            if (we) begin
                shadow[a] = d;
                wr_q.push_back({a, d});
            end else begin
                host_q.push_back(shadow[a]);
            end
        end
        tick();
        host.valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int rv0;
        int en0;
        rst        = 1'b1;
        mem_clear  = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = '0;
        host.valid = 1'b0;
        host.we    = 1'b0;
        host.addr  = '0;
        host.wdata = '0;
        for (int i = 0; i < RAM_WORDS; i++) shadow[i] = '0;
        shadow[16] = 3'b101;

        // Reset: eight edges with rst high, all outputs quiet
        tick();
        mem_clear = 1'b0;
        repeat (7) tick();
        chk("rst_outputs", {disp_valid, disp_rdata, host.ready, host.rvalid, host.rdata,
                            host_starve, ram_en, ram_we, ram_addr, ram_wdata}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(host.ready), 32'd1);

        // Single display read
        disp_req  = 1'b1;
        disp_addr = 17'h00010;
        tick();
        disp_req = 1'b0;
        repeat (4) tick();
        chk("t2_disp_cnt", 32'(disp_cnt), 32'd1);
        chk("t2_host_ready", 32'(host.ready), 32'd1);

        // Host write then read of the same word
        host_push(1'b1, 17'h00020, 3'b110);
        host_push(1'b0, 17'h00020, 3'b000);
        repeat (6) tick();
        chk("t3_rvalid_cnt", 32'(rvalid_cnt), 32'd1);

        // Fill the FIFO behind continuous display traffic, then drain
        disp_req  = 1'b1;
        disp_addr = 17'h00010;
        tick();
        for (int i = 0; i < 4; i++) host_push(1'b1, AW'(17'h00040 + i), DW'(i + 1));
        chk("t4_full_ready", 32'(host.ready), 32'd0);
        host.valid = 1'b1;
        host.we    = 1'b1;
        host.addr  = 17'h00044;
        host.wdata = 3'd5;
        tick();
        tick();
        chk("t4_still_full", 32'(host.ready), 32'd0);
        wr_cycles.delete();
        disp_req = 1'b0;
        host_push(1'b1, 17'h00044, 3'd5);
        repeat (6) tick();
        chk("t4_drain_cnt", 32'(wr_cycles.size()), 32'd5);
        if (wr_cycles.size() >= 5) chk("t4_drain_span", 32'(wr_cycles[4] - wr_cycles[0]), 32'd4);

        // Starvation flag around the MAX_WAIT boundary
        disp_req  = 1'b1;
        disp_addr = 17'h00010;
        host_push(1'b1, 17'h00030, 3'b011);
        repeat (800) tick();
        chk("t5_starve_800", 32'(host_starve), 32'd0);
        tick();
        chk("t5_starve_801", 32'(host_starve), 32'd1);
        disp_req = 1'b0;
        tick();
        chk("t5_write_issue", 32'({ram_en, ram_we}), 32'd3);
        chk("t5_starve_clear", 32'(host_starve), 32'd0);

        // Reset one cycle after a host read issues drops the response
        host_push(1'b0, 17'h00020, 3'b000);
        budget = 10;
        while (!(ram_en === 1'b1 && ram_we === 1'b0) && budget > 0) begin
            tick();
            budget--;
        end
        chk("t6_read_issued", 32'(ram_en), 32'd1);
        rv0 = rvalid_cnt;
        rst = 1'b1;
        tick();
        host_q.delete();
        host_due_q.delete();
        chk("t6_ready_in_rst", 32'(host.ready), 32'd0);
        tick();
        rst = 1'b0;
        en0 = en_cnt;
        repeat (6) tick();
        chk("t6_no_rvalid", 32'(rvalid_cnt), 32'(rv0));
        chk("t6_fifo_empty", 32'(en_cnt), 32'(en0));
        chk("t6_ready_after", 32'(host.ready), 32'd1);

        repeat (4) tick();
        chk("end_disp_q", 32'(disp_q.size()), 32'd0);
        chk("end_host_q", 32'(host_q.size()), 32'd0);
        chk("end_host_due_q", 32'(host_due_q.size()), 32'd0);
        chk("end_wr_q", 32'(wr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
